npu_out_drain: RTL and testbench

Downstream consumer of the NPU output FIFO. On a host START command it reads a programmed number of result bytes from the FIFO (RD_EN/EMPTY handshake, FIFO data on D_OUT with SSFR[15:13]=000), packs them little-endian into host-width words, and presents each word on a valid/ready interface toward the bus slave. It provides the path by which MAC/ReLU results leave the NPU.

---
 rtl/npu_out_drain.sv | 131 +++++++++++++
 tb/tb_npu_out_drain.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/npu_out_drain.sv
// Drains programmed byte count from the NPU output FIFO and packs bytes little-endian into words.
// Optional stall watchdog: define NPU_DRAIN_TIMEOUT_EN to add the TIMEOUT port and stall counter.
module npu_out_drain #(
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned CNT_W          = 8,
    parameter int unsigned TIMEOUT_CYC    = 1024
) (
    input  logic                        CLKEXT,
    input  logic                        RST_GLO,
    input  logic                        START,
    input  logic [CNT_W-1:0]            BYTE_COUNT,
    input  logic                        EMPTY,
    input  logic [7:0]                  FIFO_DATA,
    output logic                        RD_EN,
    output logic [8*BYTES_PER_WORD-1:0] WORD_OUT,
    output logic                        WORD_VALID,
    input  logic                        WORD_READY,
    output logic                        BUSY,
    output logic                        DONE,
    output logic [CNT_W-1:0]            BYTES_LEFT
`ifdef NPU_DRAIN_TIMEOUT_EN
    ,
    output logic                        TIMEOUT
`endif
);

    localparam int unsigned IDX_W = $clog2(BYTES_PER_WORD + 1);

    typedef enum logic [2:0] {IDLE, READ, CAPT, PRESENT, FIN} state_t;

    state_t                        state, state_nx;
    logic [CNT_W-1:0]              bytes_left;
    logic [IDX_W-1:0]              idx;
    logic [8*BYTES_PER_WORD-1:0]   word_q;
    logic                          stall_hit;

`ifdef NPU_DRAIN_TIMEOUT_EN
    localparam int unsigned ST_W = $clog2(TIMEOUT_CYC + 1);

    logic [ST_W-1:0] stall_cnt;
    logic            timeout_q;

    // Fires on the cycle the stall count would reach TIMEOUT_CYC.
    assign stall_hit = (state == READ) && EMPTY && (stall_cnt == ST_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge CLKEXT) begin
        if (RST_GLO) begin
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else if (state == IDLE && START) begin
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else if (RD_EN || stall_hit) begin
            stall_cnt <= '0;
            timeout_q <= timeout_q | stall_hit;
        end else if (state == READ && EMPTY) begin
            stall_cnt <= stall_cnt + ST_W'(1);
        end
    end

    assign TIMEOUT = timeout_q;
`else
    assign stall_hit = 1'b0;
`endif

    always_ff @(posedge CLKEXT) begin
        if (RST_GLO) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (START) state_nx = (BYTE_COUNT != '0) ? READ : FIN;
            READ: begin
                if (!EMPTY)         state_nx = CAPT;
                else if (stall_hit) state_nx = (idx != '0) ? PRESENT : FIN;
            end
            CAPT: begin
                if (idx == IDX_W'(BYTES_PER_WORD - 1) || bytes_left == '0) state_nx = PRESENT;
                else                                                       state_nx = READ;
            end
            PRESENT: if (WORD_READY) state_nx = (bytes_left == '0) ? FIN : READ;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLKEXT) begin
        if (RST_GLO) begin
            bytes_left <= '0;
            idx        <= '0;
            word_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (START && BYTE_COUNT != '0) begin
                        bytes_left <= BYTE_COUNT;
                        idx        <= '0;
                        word_q     <= '0;
                    end
                end
                READ: begin
                    if (!EMPTY)         bytes_left <= bytes_left - CNT_W'(1);
                    else if (stall_hit) bytes_left <= '0;
                end
                CAPT: begin
                    for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
                        if (idx == i[IDX_W-1:0]) word_q[i*8 +: 8] <= FIFO_DATA;
                    end
                    idx <= idx + IDX_W'(1);
                end
                PRESENT: begin
                    if (WORD_READY) begin
                        word_q <= '0;
                        idx    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign RD_EN      = (state == READ) && !EMPTY;
    assign WORD_VALID = (state == PRESENT);
    assign WORD_OUT   = word_q;
    assign BUSY       = (state != IDLE);
    assign DONE       = (state == FIN);
    assign BYTES_LEFT = bytes_left;

endmodule

// File: tb/tb_npu_out_drain.sv
// Directed + randomized checks of npu_out_drain (default build) against a byte-stream packing model.
module tb_npu_out_drain;

    localparam int BPW = 4;
    localparam int CW  = 8;

    logic            clk = 1'b0;
    logic            rst, start, empty, word_ready;
    logic [CW-1:0]   byte_count;
    logic [7:0]      fifo_data;
    logic            rd_en, word_valid, busy, done;
    logic [8*BPW-1:0] word_out;
    logic [CW-1:0]   bytes_left;

    npu_out_drain #(.BYTES_PER_WORD(BPW), .CNT_W(CW), .TIMEOUT_CYC(1024)) dut (
        .CLKEXT(clk), .RST_GLO(rst), .START(start), .BYTE_COUNT(byte_count),
        .EMPTY(empty), .FIFO_DATA(fifo_data), .RD_EN(rd_en), .WORD_OUT(word_out),
        .WORD_VALID(word_valid), .WORD_READY(word_ready), .BUSY(busy), .DONE(done),
        .BYTES_LEFT(bytes_left)
    );

    always #5 clk = ~clk;

    int          n_vec = 0, n_fail = 0;
    logic [7:0]  mem [1024];
    int          rd_ptr = 0, wr_ptr = 0;
    bit          rd_pend = 0, hold_empty = 0;
    logic [31:0] first_word, last_word;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // FIFO model: data appears the cycle after an accepted read.
    task automatic cyc_begin();
        @(posedge clk); #1;
        if (rd_pend) begin
            fifo_data = mem[rd_ptr];
            rd_ptr++;
        end
        rd_pend = 0;
    endtask

    task automatic cyc_sample();
        empty = hold_empty || (rd_ptr == wr_ptr);
        #1;
        rd_pend = rd_en && !empty;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr++;
    endtask

    function automatic int rd_cyc(input int k);
        return 1 + 2*k + k/BPW;
    endfunction

    function automatic int val_cyc(input int w, input int n);
        int last;
        last = (((w+1)*BPW < n) ? (w+1)*BPW : n) - 1;
        return rd_cyc(last) + 2;
    endfunction

    function automatic bit rd_at(input int c, input int n);
        for (int k = 0; k < n; k++) if (rd_cyc(k) == c) return 1;
        return 0;
    endfunction

    function automatic bit val_at(input int c, input int n);
        for (int w = 0; w < (n + BPW - 1)/BPW; w++) if (val_cyc(w, n) == c) return 1;
        return 0;
    endfunction

    task automatic run_job(input int n, input bit timed, input int ready_low,
                           input int stall_after, input int stall_len, input int restart_at);
        int          base, nwords, widx, reads, dones, stall_left, done_c, low_left;
        bit          stall_used, prev_rd, held, fin;
        logic [31:0] expw [$];
        logic [31:0] w, held_word;
        logic [CW-1:0] prev_left;
        base   = rd_ptr;
        nwords = (n + BPW - 1) / BPW;
        for (int i = 0; i < nwords; i++) begin
            w = '0;
            for (int b = 0; b < BPW; b++)
                if (i*BPW + b < n) w[b*8 +: 8] = mem[base + i*BPW + b];
            expw.push_back(w);
        end
        done_c = (n == 0) ? 1 : val_cyc(nwords - 1, n) + 1;
        widx = 0; reads = 0; dones = 0; stall_left = 0; stall_used = 0;
        prev_rd = 0; held = 0; fin = 0; low_left = ready_low; prev_left = '0;

        cyc_begin();
        start = 1; byte_count = CW'(n); word_ready = 1;
        cyc_sample();

        for (int c = 1; c < 40*n + 60 && !fin; c++) begin
            cyc_begin();
            start      = (c == restart_at);
            byte_count = CW'($urandom);
            if (!stall_used && stall_len > 0 && reads == stall_after) begin
                stall_used = 1;
                stall_left = stall_len;
            end
            hold_empty = (stall_left > 0);
            word_ready = (low_left == 0);
            cyc_sample();

            chk("bytes_left", bytes_left, CW'(n - reads));
            chk("rd_while_valid", rd_en & word_valid, 0);
            chk("rd_back_to_back", rd_en & prev_rd, 0);
            chk("busy_in_job", busy, 1);
            if (timed) begin
                chk("rd_timing", rd_en, rd_at(c, n));
                chk("valid_timing", word_valid, val_at(c, n));
                chk("done_timing", done, c == done_c);
            end
            if (stall_left > 0) begin
                chk("stall_no_rd", rd_en, 0);
                if (c > 1 && stall_left < stall_len) chk("stall_frozen", bytes_left, prev_left);
                stall_left--;
            end
            if (word_valid) begin
                if (held) chk("word_stable", word_out, held_word);
                if (word_ready) begin
                    chk("word_data", word_out, (widx < nwords) ? expw[widx] : 32'hx);
                    if (widx == 0) first_word = word_out;
                    last_word = word_out;
                    widx++;
                    held = 0;
                end else begin
                    held      = 1;
                    held_word = word_out;
                    low_left--;
                end
            end
            if (rd_en) reads++;
            if (done) begin
                dones++;
                fin = 1;
            end
            prev_rd   = rd_en;
            prev_left = bytes_left;
        end
        hold_empty = 0;
        chk("job_completed", fin, 1);
        chk("word_count", widx, nwords);
        chk("read_count", reads, n);
        chk("done_count", dones, 1);
        chk("ready_low_served", low_left, 0);

        cyc_begin();
        start = 0; word_ready = 1;
        cyc_sample();
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_bytes_left", bytes_left, 0);
    endtask

    initial begin
        int reads;
        rst = 1; start = 0; byte_count = '0; word_ready = 1; fifo_data = '0; empty = 1;
        first_word = '0; last_word = '0;
        repeat (2) begin cyc_begin(); cyc_sample(); end
        chk("rst_rd_en", rd_en, 0);
        chk("rst_valid", word_valid, 0);
        chk("rst_word", word_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bytes_left", bytes_left, 0);
        cyc_begin(); rst = 0; cyc_sample();

        for (int i = 1; i <= 8; i++) push(8'(i));
        run_job(8, 1, 0, 0, 0, 0);
        chk("w0_const", first_word, 32'h04030201);
        chk("w1_const", last_word, 32'h08070605);

        push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD); push(8'hEE);
        run_job(5, 1, 0, 0, 0, 0);
        chk("pad_const", last_word, 32'h000000EE);

        for (int i = 0; i < 4; i++) push(8'($urandom));
        run_job(4, 0, 20, 0, 0, 0);

        for (int i = 0; i < 8; i++) push(8'($urandom));
        run_job(8, 0, 0, 2, 10, 0);

        run_job(0, 1, 0, 0, 0, 0);

        for (int i = 0; i < 4; i++) push(8'($urandom));
        run_job(4, 0, 0, 0, 0, 3);

        // Abort a job with reset in the capture of the third byte.
        for (int i = 0; i < 8; i++) push(8'($urandom));
        cyc_begin(); start = 1; byte_count = 8'd8; cyc_sample();
        reads = 0;
        for (int c = 0; c < 40 && reads < 3; c++) begin
            cyc_begin(); start = 0; cyc_sample();
            if (rd_en) reads++;
        end
        chk("abort_reads", reads, 3);
        cyc_begin(); rst = 1; cyc_sample();
        chk("abort_in_capt_busy", busy, 1);
        chk("abort_in_capt_rd", rd_en, 0);
        cyc_begin(); cyc_sample();
        chk("abort_rd_en", rd_en, 0);
        chk("abort_valid", word_valid, 0);
        chk("abort_word", word_out, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_bytes_left", bytes_left, 0);
        cyc_begin(); rst = 0; rd_pend = 0; rd_ptr = wr_ptr; cyc_sample();
        for (int i = 0; i < 4; i++) push(8'($urandom));
        run_job(4, 1, 0, 0, 0, 0);

        for (int j = 0; j < 6; j++) begin
            int n;
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) push(8'($urandom));
            run_job(n, 0, $urandom_range(0, 5), $urandom_range(0, n - 1),
                    $urandom_range(0, 6), $urandom_range(0, 8));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
